// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for a 5-stage in-order pipeline.
//
// Tracks the destination tags of the instructions sitting in EX and MEM and, on
// each edge, registers the ALU operand-select codes for the instruction that is
// moving from ID into EX. A combinational stall holds PC and IF/ID for one cycle
// when the ID instruction reads the destination of a load that is currently in EX.
// A taken branch (flush) kills the ID instruction. A saturating counter records
// the number of stall cycles for performance debug.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   id_valid              instruction in ID is valid
//   id_rs1, id_rs2        ID source register addresses
//   id_rs1_used/_rs2_used ID instruction actually reads rs1 / rs2
//   id_rd                 ID destination register address
//   id_regwrite           ID instruction writes the register file
//   id_memread            ID instruction is a load
//   flush                 kill the ID instruction (branch taken in EX)
//   stall                 hold PC and IF/ID this cycle (combinational)
//   fwd1_sel, fwd2_sel    EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   ex_valid              EX holds a real instruction
//   stall_count           saturating count of stall cycles
//
// The WB copy of the tag and the MEM memread flag are not stored: the register
// file is write-before-read, so nothing downstream of MEM is ever forwarded, and
// only a load still in EX can cause a stall.
module fwd_hazard_unit #(
  parameter int unsigned AW           = 3,
  parameter int unsigned R0_HARDWIRED = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_count
);

  // EX stage tag
  logic          ex_v_q, ex_rw_q, ex_mr_q;
  logic [AW-1:0] ex_rd_q;
  // MEM stage tag
  logic          mem_v_q, mem_rw_q;
  logic [AW-1:0] mem_rd_q;

  logic [1:0]       fwd1_sel_q, fwd1_sel_d;
  logic [1:0]       fwd2_sel_q, fwd2_sel_d;
  logic [CNT_W-1:0] cnt_q;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic load_ex;

  // A producer matches a source address only if it is live and writes the
  // register file; address 0 never matches when r0 is hardwired to zero.
  function automatic logic tag_match(input logic          v,
                                     input logic          rw,
                                     input logic [AW-1:0] rd,
                                     input logic [AW-1:0] a);
    logic is_r0;
    is_r0 = (R0_HARDWIRED != 0) && (a == '0);
    return v && rw && (rd == a) && !is_r0;
  endfunction

  always_comb begin
    ex_hit1  = id_rs1_used && tag_match(ex_v_q, ex_rw_q, ex_rd_q, id_rs1);
    ex_hit2  = id_rs2_used && tag_match(ex_v_q, ex_rw_q, ex_rd_q, id_rs2);
    mem_hit1 = id_rs1_used && tag_match(mem_v_q, mem_rw_q, mem_rd_q, id_rs1);
    mem_hit2 = id_rs2_used && tag_match(mem_v_q, mem_rw_q, mem_rd_q, id_rs2);

    // flush wins over stall; reset suppresses stall entirely
    stall   = rst_n && id_valid && !flush && ex_mr_q && (ex_hit1 || ex_hit2);
    load_ex = id_valid && !flush && !stall;

    // Youngest producer (EX) wins over MEM; a bubble gets regfile selects.
    fwd1_sel_d = 2'b00;
    fwd2_sel_d = 2'b00;
    if (load_ex) begin
      if (ex_hit1)       fwd1_sel_d = 2'b01;
      else if (mem_hit1) fwd1_sel_d = 2'b10;
      if (ex_hit2)       fwd2_sel_d = 2'b01;
      else if (mem_hit2) fwd2_sel_d = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v_q     <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_rd_q    <= '0;
      mem_v_q    <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_rd_q   <= '0;
      fwd1_sel_q <= 2'b00;
      fwd2_sel_q <= 2'b00;
      cnt_q      <= '0;
    end else begin
      // MEM always advances; only the ID->EX transfer is gated
      mem_v_q    <= ex_v_q;
      mem_rw_q   <= ex_rw_q;
      mem_rd_q   <= ex_rd_q;
      ex_v_q     <= load_ex;
      ex_rw_q    <= load_ex && id_regwrite;
      ex_mr_q    <= load_ex && id_memread;
      ex_rd_q    <= id_rd;
      fwd1_sel_q <= fwd1_sel_d;
      fwd2_sel_q <= fwd2_sel_d;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign fwd1_sel    = fwd1_sel_q;
  assign fwd2_sel    = fwd2_sel_q;
  assign ex_valid    = ex_v_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit. Two instances share the stimulus:
// dut uses the default 16-bit stall counter, dut_b a 2-bit one for saturation.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_regwrite, id_memread, flush;

  logic        stall, ex_valid;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [15:0] stall_count;
  logic        stall_b, ex_valid_b;
  logic [1:0]  fwd1_sel_b, fwd2_sel_b;
  logic [1:0]  stall_count_b;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic        exv;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;

  fwd_hazard_unit #(.AW(3), .R0_HARDWIRED(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .stall(stall),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .ex_valid(ex_valid), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.AW(3), .R0_HARDWIRED(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .stall(stall_b),
    .fwd1_sel(fwd1_sel_b), .fwd2_sel(fwd2_sel_b), .ex_valid(ex_valid_b),
    .stall_count(stall_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic stim_t mk(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic u1, input logic u2, input logic [2:0] rd,
                               input logic rw, input logic mr, input logic fl);
    stim_t s;
    s = '{v: v, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, rw: rw, mr: mr, fl: fl};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_valid    = s.v;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_rs1_used = s.u1;
    id_rs2_used = s.u2;
    id_rd       = s.rd;
    id_regwrite = s.rw;
    id_memread  = s.mr;
    flush       = s.fl;
  endtask

  // Expectation producer: {stall, f1, f2, exv}; stall counters are modelled here.
  task automatic push_exp(input logic [5:0] x);
    exp_t e;
    if (x[5]) begin
      exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
    end
    e = '{stall: x[5], f1: x[4:3], f2: x[2:1], exv: x[0], cnt: exp_cnt, cnt2: exp_cnt2};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(mk(1, 3'd1, 3'd1, 1, 1, 3'd1, 1, 1, 0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({stall, stall_b, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b} !== '0) begin
        failures++;
        $display("FAIL reset[%0d] got stall=%b f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp all zero",
                 i, stall, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b);
      end
    end
    rst_n    = 1'b1;
    exp_cnt  = '0;
    exp_cnt2 = '0;
  endtask

  task automatic test_alu_fwd();
    stim_t st[5];
    logic [5:0] ex[5];
    exp_t e;
    st[0] = mk(1, 3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 0); ex[0] = 6'b0_00_00_1;
    st[1] = mk(1, 3'd3, 3'd0, 1, 0, 3'd6, 1, 0, 0); ex[1] = 6'b0_01_00_1;
    st[2] = mk(1, 3'd1, 3'd3, 1, 1, 3'd7, 1, 0, 0); ex[2] = 6'b0_00_10_1;
    st[3] = mk(1, 3'd6, 3'd3, 1, 1, 3'd0, 0, 0, 0); ex[3] = 6'b0_10_00_1;
    st[4] = mk(1, 3'd7, 3'd7, 0, 1, 3'd1, 0, 0, 0); ex[4] = 6'b0_00_10_1;
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      push_exp(ex[i]);
      @(negedge clk);
      checks++;
      if ({stall, stall_b} !== {2{sb[0].stall}}) begin
        failures++;
        $display("FAIL alu_fwd[%0d] stall got=%b/%b exp=%b", i, stall, stall_b, sb[0].stall);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({fwd1_sel, fwd2_sel, ex_valid, stall_count, fwd1_sel_b, fwd2_sel_b, ex_valid_b,
           stall_count_b} !== {e.f1, e.f2, e.exv, e.cnt, e.f1, e.f2, e.exv, e.cnt2}) begin
        failures++;
        $display("FAIL alu_fwd[%0d] got f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d",
                 i, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b,
                 e.f1, e.f2, e.exv, e.cnt, e.cnt2);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[10];
    logic [5:0] ex[10];
    exp_t e;
    st[0] = mk(1, 3'd1, 3'd0, 1, 0, 3'd5, 1, 1, 0); ex[0] = 6'b0_00_00_1;
    st[1] = mk(1, 3'd5, 3'd0, 1, 0, 3'd6, 1, 0, 0); ex[1] = 6'b1_00_00_0;
    st[2] = st[1];                                  ex[2] = 6'b0_10_00_1;
    st[3] = mk(1, 3'd0, 3'd0, 1, 0, 3'd4, 1, 1, 0); ex[3] = 6'b0_00_00_1;
    st[4] = mk(1, 3'd1, 3'd4, 1, 1, 3'd2, 1, 0, 0); ex[4] = 6'b1_00_00_0;
    st[5] = st[4];                                  ex[5] = 6'b0_00_10_1;
    st[6] = mk(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0); ex[6] = 6'b0_00_00_1;
    st[7] = mk(1, 3'd3, 3'd3, 0, 0, 3'd0, 0, 0, 0); ex[7] = 6'b0_00_00_1;
    st[8] = mk(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0); ex[8] = 6'b0_00_00_1;
    st[9] = mk(0, 3'd3, 3'd0, 1, 0, 3'd0, 0, 0, 0); ex[9] = 6'b0_00_00_0;
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      push_exp(ex[i]);
      @(negedge clk);
      checks++;
      if ({stall, stall_b} !== {2{sb[0].stall}}) begin
        failures++;
        $display("FAIL load_use[%0d] stall got=%b/%b exp=%b", i, stall, stall_b, sb[0].stall);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({fwd1_sel, fwd2_sel, ex_valid, stall_count, fwd1_sel_b, fwd2_sel_b, ex_valid_b,
           stall_count_b} !== {e.f1, e.f2, e.exv, e.cnt, e.f1, e.f2, e.exv, e.cnt2}) begin
        failures++;
        $display("FAIL load_use[%0d] got f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d",
                 i, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b,
                 e.f1, e.f2, e.exv, e.cnt, e.cnt2);
      end
    end
  endtask

  task automatic test_priority_r0();
    stim_t st[6];
    logic [5:0] ex[6];
    exp_t e;
    st[0] = mk(1, 3'd7, 3'd0, 1, 0, 3'd2, 1, 0, 0); ex[0] = 6'b0_00_00_1;
    st[1] = mk(1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 0, 0); ex[1] = 6'b0_00_00_1;
    st[2] = mk(1, 3'd2, 3'd2, 1, 1, 3'd5, 0, 0, 0); ex[2] = 6'b0_01_01_1;
    st[3] = mk(1, 3'd1, 3'd0, 1, 0, 3'd0, 1, 1, 0); ex[3] = 6'b0_00_00_1;
    st[4] = mk(1, 3'd0, 3'd0, 1, 1, 3'd0, 1, 0, 0); ex[4] = 6'b0_00_00_1;
    st[5] = mk(1, 3'd0, 3'd1, 1, 1, 3'd1, 0, 0, 0); ex[5] = 6'b0_00_00_1;
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      push_exp(ex[i]);
      @(negedge clk);
      checks++;
      if ({stall, stall_b} !== {2{sb[0].stall}}) begin
        failures++;
        $display("FAIL prio_r0[%0d] stall got=%b/%b exp=%b", i, stall, stall_b, sb[0].stall);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({fwd1_sel, fwd2_sel, ex_valid, stall_count, fwd1_sel_b, fwd2_sel_b, ex_valid_b,
           stall_count_b} !== {e.f1, e.f2, e.exv, e.cnt, e.f1, e.f2, e.exv, e.cnt2}) begin
        failures++;
        $display("FAIL prio_r0[%0d] got f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d",
                 i, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b,
                 e.f1, e.f2, e.exv, e.cnt, e.cnt2);
      end
    end
  endtask

  task automatic test_flush();
    stim_t st[5];
    logic [5:0] ex[5];
    exp_t e;
    st[0] = mk(1, 3'd1, 3'd0, 1, 0, 3'd4, 1, 1, 0); ex[0] = 6'b0_00_00_1;
    st[1] = mk(1, 3'd4, 3'd0, 1, 0, 3'd6, 1, 0, 1); ex[1] = 6'b0_00_00_0;
    st[2] = mk(1, 3'd4, 3'd0, 1, 0, 3'd6, 1, 0, 0); ex[2] = 6'b0_10_00_1;
    st[3] = mk(1, 3'd0, 3'd0, 1, 0, 3'd3, 1, 0, 1); ex[3] = 6'b0_00_00_0;
    st[4] = mk(1, 3'd3, 3'd0, 1, 0, 3'd0, 0, 0, 0); ex[4] = 6'b0_00_00_1;
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      push_exp(ex[i]);
      @(negedge clk);
      checks++;
      if ({stall, stall_b} !== {2{sb[0].stall}}) begin
        failures++;
        $display("FAIL flush[%0d] stall got=%b/%b exp=%b", i, stall, stall_b, sb[0].stall);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({fwd1_sel, fwd2_sel, ex_valid, stall_count, fwd1_sel_b, fwd2_sel_b, ex_valid_b,
           stall_count_b} !== {e.f1, e.f2, e.exv, e.cnt, e.f1, e.f2, e.exv, e.cnt2}) begin
        failures++;
        $display("FAIL flush[%0d] got f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d",
                 i, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b,
                 e.f1, e.f2, e.exv, e.cnt, e.cnt2);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t st[3];
    logic [5:0] ex[3];
    exp_t e;
    st[0] = mk(1, 3'd0, 3'd0, 1, 0, 3'd5, 1, 1, 0); ex[0] = 6'b0_00_00_1;
    st[1] = mk(1, 3'd5, 3'd0, 1, 0, 3'd6, 1, 0, 0); ex[1] = 6'b1_00_00_0;
    st[2] = st[1];                                  ex[2] = 6'b0_10_00_1;
    for (int n = 0; n < 15; n++) begin
      drive(st[n % 3]);
      push_exp(ex[n % 3]);
      @(negedge clk);
      checks++;
      if ({stall, stall_b} !== {2{sb[0].stall}}) begin
        failures++;
        $display("FAIL sat[%0d] stall got=%b/%b exp=%b", n, stall, stall_b, sb[0].stall);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({fwd1_sel, fwd2_sel, ex_valid, stall_count, fwd1_sel_b, fwd2_sel_b, ex_valid_b,
           stall_count_b} !== {e.f1, e.f2, e.exv, e.cnt, e.f1, e.f2, e.exv, e.cnt2}) begin
        failures++;
        $display("FAIL sat[%0d] got f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d",
                 n, fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b,
                 e.f1, e.f2, e.exv, e.cnt, e.cnt2);
      end
    end
    // 2 stalls from the load-use test plus 5 here
    checks++;
    if (stall_count !== 16'd7 || stall_count_b !== 2'd3) begin
      failures++;
      $display("FAIL sat_final got cnt=%0d cnt2=%0d exp cnt=7 cnt2=3", stall_count, stall_count_b);
    end
  endtask

  task automatic test_reset_mid();
    // load rd=5 into EX
    drive(mk(1, 3'd0, 3'd0, 1, 0, 3'd5, 1, 1, 0));
    @(posedge clk); #1;
    // reset while dependent instruction sits in ID
    rst_n = 1'b0;
    drive(mk(1, 3'd5, 3'd5, 1, 1, 3'd6, 1, 0, 0));
    #1;
    checks++;
    if ({stall, stall_b} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_stall got=%b/%b exp=0", stall, stall_b);
    end
    @(posedge clk); #1;
    checks++;
    if ({fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b} !== '0) begin
      failures++;
      $display("FAIL reset_mid_regs got f1=%b f2=%b exv=%b cnt=%0d cnt2=%0d exp all zero",
               fwd1_sel, fwd2_sel, ex_valid, stall_count, stall_count_b);
    end
    rst_n    = 1'b1;
    exp_cnt  = '0;
    exp_cnt2 = '0;
    #1;
    checks++;
    if ({stall, stall_b} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_after_stall got=%b/%b exp=0", stall, stall_b);
    end
    @(posedge clk); #1;
    checks++;
    if ({fwd1_sel, fwd2_sel, ex_valid, stall_count} !== {2'b00, 2'b00, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL reset_mid_after got f1=%b f2=%b exv=%b cnt=%0d exp f1=00 f2=00 exv=1 cnt=0",
               fwd1_sel, fwd2_sel, ex_valid, stall_count);
    end
  endtask

  initial begin
    exp_cnt  = '0;
    exp_cnt2 = '0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority_r0();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard controller for the 5-stage pipeline.
- Internally tracks destination tags of in-flight instructions (EX, MEM, WB) and registers ALU operand-select codes for the instruction entering EX.
- Raises a combinational load-use stall to hold IF/ID.
- Handles branch flush and keeps a saturating stall-cycle counter for performance debug.

Parameters:
AW, 3, register-address width
R0_HARDWIRED, 1, if 1 then address 0 never matches (no forward, no stall)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  instruction in ID is valid
id_rs1  in  AW  ID source 1 address
id_rs2  in  AW  ID source 2 address
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd  in  AW  ID destination address
id_regwrite  in  1  ID instruction writes register file
id_memread  in  1  ID instruction is a load
flush  in  1  kill ID instruction (branch taken in EX)
stall  out  1  hold PC and IF/ID this cycle (combinational)
fwd1_sel  out  2  operand-1 select for EX: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd2_sel  out  2  operand-2 select, same encoding
ex_valid  out  1  EX stage holds a real instruction
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: rst_n sampled on rising clk; when 0:
  - clear EX/MEM/WB valid bits, regwrite, memread.
  - fwd1_sel=fwd2_sel=00, ex_valid=0, stall_count=0.
  - stall forced 0 while rst_n=0.
  - Reset mid-operation discards all in-flight tags; the first instruction after reset sees no hazards.
- Internal stage registers:
  - EX: {v, rd, regwrite, memread}.
  - MEM: {v, rd, regwrite, memread}.
  - WB: {v, rd, regwrite}.
- match(s, a): s.v & s.regwrite & (s.rd==a) & !(R0_HARDWIRED & a==0).
- stall = rst_n & id_valid & !flush & EX.memread & ((id_rs1_used & match(EX, id_rs1)) | (id_rs2_used & match(EX, id_rs2))).
- Every clock, when not in reset:
  - WB <= MEM; MEM <= EX (always advance, never stalled).
  - If id_valid & !flush & !stall: EX <= ID fields, v=1. Otherwise EX <= bubble (v=0, regwrite=0, memread=0).
- Forward selects are registered on the same edge as EX load, for the incoming ID instruction, evaluated against pre-edge EX/MEM state:
  - fwdN_sel <= 01 if rsN_used & match(EX, rsN).
  - else 10 if rsN_used & match(MEM, rsN).
  - else 00.
  - The most recent producer (EX) wins when both match.
  - Bubble loaded into EX → both sels 00.
- Latency:
  - Load-use dependency costs exactly 1 stall cycle.
  - The re-presented instruction then gets sel 10 (load now in WB-bound MEM slot).
- flush has priority over stall: flush=1 → stall=0, EX <= bubble.
- stall_count increments by 1 on each clock with stall=1; holds at 2^CNT_W-1.
- ex_valid = EX.v.
- No regfile write-through is provided by this block; the regfile must be write-before-read.

Test Plan:
- Reset then idle: rst_n=0 two cycles with id_valid=1 → stall=0, sels 00, stall_count=0, ex_valid=0.
- Back-to-back ALU dependency: add rd=3, next instr rs1=3 used → on second edge fwd1_sel=01. Instr two later with rs2=3 → fwd2_sel=10.
- Load-use: lw rd=5, next rs1=5 used →
  - stall=1 for one cycle, EX bubble, stall_count=1.
  - re-presented instr gets fwd1_sel=10, stall=0.
- Priority and r0:
  - EX and MEM both write rd=2, ID rs1=2 → fwd1_sel=01.
  - rd=0 producer with R0_HARDWIRED=1 → sels 00, no stall on load to r0.
- Flush: load rd=4 in EX, ID rs1=4, flush=1 → stall=0, next ex_valid=0, stall_count unchanged.
- Saturation and reset mid-run: CNT_W=2 with 5 load-use stalls → stall_count=3. Then rst_n=0 one cycle while a load is in EX → dependent instr afterwards sees stall=0 and sels 00.
